// File: rtl/ro_sched_pkg.sv
// Shared constants and parameter derivations for the readout slot scheduler.
package ro_sched_pkg;

  localparam int unsigned RO_N_CH_DEFAULT = 4;

  // Slot indices are carried at a fixed width wide enough for any sane CNT_W.
  localparam int unsigned SLOT_W = 8;
  typedef logic [SLOT_W-1:0] slot_t;

  // Slot kind codes produced by the decoder.
  localparam logic [1:0] KIND_OFF   = 2'd0;
  localparam logic [1:0] KIND_GRANT = 2'd1;
  localparam logic [1:0] KIND_IDLE  = 2'd2;
  localparam logic [1:0] KIND_WRAP  = 2'd3;

  function automatic int unsigned ro_cnt_w(input int unsigned n_ch);
    return n_ch + 1;
  endfunction

  function automatic int unsigned ro_ch_w(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/ro_slot_decode.sv
// Trailing-zero priority encoder: maps the incremented slot count to a slot index,
// a slot kind and a one-hot channel grant.
module ro_slot_decode
  import ro_sched_pkg::*;
#(
  parameter int unsigned N_CH  = RO_N_CH_DEFAULT,
  parameter int unsigned CNT_W = ro_cnt_w(N_CH)
) (
  input  logic             en_i,
  input  logic [CNT_W-1:0] inc_i,
  output slot_t            slot_o,
  output logic [1:0]       kind_o,
  output logic [N_CH-1:0]  grant_o
);

  // Scan from MSB down so the lowest set bit wins; an all-zero count yields CNT_W.
  always_comb begin
    slot_o = slot_t'(CNT_W);
    for (int i = CNT_W - 1; i >= 0; i--) begin
      if (inc_i[i]) begin
        slot_o = slot_t'(i);
      end
    end
  end

  always_comb begin
    kind_o  = KIND_OFF;
    grant_o = '0;
    if (en_i) begin
      if (slot_o < slot_t'(N_CH)) begin
        kind_o = KIND_GRANT;
        for (int k = 0; k < N_CH; k++) begin
          grant_o[k] = (slot_o == slot_t'(k));
        end
      end else if (inc_i == '0) begin
        kind_o = KIND_WRAP;
      end else begin
        kind_o = KIND_IDLE;
      end
    end
  end

endmodule

// File: rtl/ro_scheduler.sv
// Binary-tree readout scheduler: channel k owns the shared bus every 2^(k+1) cycles.
// Optional frame marker on count wrap is enabled with RO_SCHED_FRAME_MARKER_EN.
module ro_scheduler
  import ro_sched_pkg::*;
#(
  parameter int unsigned N_CH  = RO_N_CH_DEFAULT,
  parameter int unsigned CNT_W = ro_cnt_w(N_CH),
  parameter int unsigned CH_W  = ro_ch_w(N_CH)
) (
  input  logic             clk_master,
  input  logic             reset,
  input  logic             en,
  input  logic [N_CH-1:0]  ch_valid,
  input  logic [N_CH-1:0]  ch_eve,
  input  logic [N_CH-1:0]  ch_pol_eve,
  output logic [N_CH-1:0]  ch_ack,
  output logic             bus_valid,
  output logic             bus_eve,
  output logic             bus_pol_eve,
  output logic [CH_W-1:0]  bus_ch,
  output logic [CNT_W-1:0] gray,
  output logic [N_CH-1:0]  ovf
`ifdef RO_SCHED_FRAME_MARKER_EN
  ,
  output logic             bus_marker
`endif
);

  logic [CNT_W-1:0] bin_q, bin_d, inc;
  logic [CNT_W-1:0] gray_q, gray_d;
  logic [N_CH-1:0]  pending_q, pending_d;
  logic [N_CH-1:0]  eve_q, eve_d;
  logic [N_CH-1:0]  pol_q, pol_d;
  logic [N_CH-1:0]  ovf_q, ovf_d;
  logic [N_CH-1:0]  ack_q, ack_d;
  logic             bus_valid_q, bus_valid_d;
  logic             bus_eve_q, bus_eve_d;
  logic             bus_pol_q, bus_pol_d;
  logic [CH_W-1:0]  bus_ch_q, bus_ch_d;

  slot_t            slot;
  logic [1:0]       kind;
  logic [N_CH-1:0]  grant;
  logic [N_CH-1:0]  drain;
  logic [N_CH-1:0]  capture;

  assign inc = bin_q + CNT_W'(1);

  ro_slot_decode #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W)
  ) u_slot_decode (
    .en_i    (en),
    .inc_i   (inc),
    .slot_o  (slot),
    .kind_o  (kind),
    .grant_o (grant)
  );

  always_comb begin
    bin_d  = bin_q;
    gray_d = gray_q;
    if (en) begin
      bin_d  = inc;
      gray_d = inc ^ (inc >> 1);
    end
  end

  // A drain frees the buffer in the same cycle, so a coincident sample is taken, not dropped.
  always_comb begin
    drain     = grant & pending_q;
    capture   = '0;
    pending_d = pending_q;
    eve_d     = eve_q;
    pol_d     = pol_q;
    ovf_d     = ovf_q;
    for (int k = 0; k < N_CH; k++) begin
      capture[k] = ch_valid[k] & (~pending_q[k] | drain[k]);
      if (capture[k]) begin
        pending_d[k] = 1'b1;
        eve_d[k]     = ch_eve[k];
        pol_d[k]     = ch_pol_eve[k];
      end else if (drain[k]) begin
        pending_d[k] = 1'b0;
      end
      if (ch_valid[k] && pending_q[k] && !drain[k]) begin
        ovf_d[k] = 1'b1;
      end
    end
    ack_d = capture;
  end

  always_comb begin
    bus_valid_d = 1'b0;
    bus_ch_d    = bus_ch_q;
    bus_eve_d   = bus_eve_q;
    bus_pol_d   = bus_pol_q;
    case (kind)
      KIND_GRANT: begin
        bus_valid_d = |drain;
        bus_ch_d    = CH_W'(slot);
        bus_eve_d   = |(grant & eve_q);
        bus_pol_d   = |(grant & pol_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_master) begin
    if (reset) begin
      bin_q       <= '0;
      gray_q      <= '0;
      pending_q   <= '0;
      eve_q       <= '0;
      pol_q       <= '0;
      ovf_q       <= '0;
      ack_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_eve_q   <= 1'b0;
      bus_pol_q   <= 1'b0;
      bus_ch_q    <= '0;
    end else begin
      bin_q       <= bin_d;
      gray_q      <= gray_d;
      pending_q   <= pending_d;
      eve_q       <= eve_d;
      pol_q       <= pol_d;
      ovf_q       <= ovf_d;
      ack_q       <= ack_d;
      bus_valid_q <= bus_valid_d;
      bus_eve_q   <= bus_eve_d;
      bus_pol_q   <= bus_pol_d;
      bus_ch_q    <= bus_ch_d;
    end
  end

`ifdef RO_SCHED_FRAME_MARKER_EN
  logic marker_q, marker_d;

  always_comb begin
    marker_d = (kind == KIND_WRAP);
  end

  always_ff @(posedge clk_master) begin
    if (reset) begin
      marker_q <= 1'b0;
    end else begin
      marker_q <= marker_d;
    end
  end

  assign bus_marker = marker_q;
`endif

  assign gray        = gray_q;
  assign ch_ack      = ack_q;
  assign ovf         = ovf_q;
  assign bus_valid   = bus_valid_q;
  assign bus_eve     = bus_eve_q;
  assign bus_pol_eve = bus_pol_q;
  assign bus_ch      = bus_ch_q;

endmodule

// File: tb/tb_ro_scheduler.sv
// Scoreboard bench for ro_scheduler (N_CH=4, CNT_W=5); marker checks under RO_SCHED_FRAME_MARKER_EN.
module tb_ro_scheduler;

  logic       clk_master = 1'b0;
  logic       reset      = 1'b1;
  logic       en         = 1'b0;
  logic [3:0] ch_valid   = '0;
  logic [3:0] ch_eve     = '0;
  logic [3:0] ch_pol_eve = '0;
  logic [3:0] ch_ack;
  logic [3:0] ovf;
  logic       bus_valid, bus_eve, bus_pol_eve;
  logic [1:0] bus_ch;
  logic [4:0] gray;
`ifdef RO_SCHED_FRAME_MARKER_EN
  logic       bus_marker;
`endif

  typedef struct packed {
    logic [1:0] ch;
    logic       eve;
    logic       pol;
    logic [4:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [4:0] model_bin = '0;
  logic       model_en  = 1'b0;
  logic       model_ok  = 1'b0;

  always #5 clk_master = ~clk_master;

  ro_scheduler dut (
    .clk_master  (clk_master),
    .reset       (reset),
    .en          (en),
    .ch_valid    (ch_valid),
    .ch_eve      (ch_eve),
    .ch_pol_eve  (ch_pol_eve),
    .ch_ack      (ch_ack),
    .bus_valid   (bus_valid),
    .bus_eve     (bus_eve),
    .bus_pol_eve (bus_pol_eve),
    .bus_ch      (bus_ch),
    .gray        (gray),
    .ovf         (ovf)
`ifdef RO_SCHED_FRAME_MARKER_EN
    ,
    .bus_marker  (bus_marker)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (count %0d, t=%0t)", name, act, exp, model_bin, $time);
    end
  endtask

  // Reference slot counter.
  always @(posedge clk_master) begin
    model_ok <= model_ok | reset;
    model_en <= en & ~reset;
    if (reset) model_bin <= '0;
    else if (en) model_bin <= model_bin + 5'd1;
  end

  // Monitor: gray tracking, bus scoreboard, marker.
  always @(posedge clk_master) begin
    exp_t e;
    #1;
    if (model_ok) begin
      check("gray_track", 32'(gray), 32'(model_bin ^ (model_bin >> 1)));
      if (!model_en) check("bus_valid_disabled", 32'(bus_valid), 32'd0);
      if (bus_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL bus_unexpected: got bus_valid=1 ch=%0d expected no transfer (count %0d)",
                   bus_ch, model_bin);
        end else begin
          e = exp_q.pop_front();
          check("bus_ch", 32'(bus_ch), 32'(e.ch));
          check("bus_eve", 32'(bus_eve), 32'(e.eve));
          check("bus_pol_eve", 32'(bus_pol_eve), 32'(e.pol));
          check("bus_count", 32'(model_bin), 32'(e.cnt));
        end
      end
`ifdef RO_SCHED_FRAME_MARKER_EN
      check("bus_marker", 32'(bus_marker), 32'(model_en && (model_bin == 5'd0)));
`endif
    end
  end

  task automatic wait_count(input logic [4:0] c);
    int n = 0;
    while (model_bin != c && n < 200) begin
      @(negedge clk_master);
      n++;
    end
    check("wait_count_timeout", 32'(n >= 200), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gray"}, 32'(gray), 32'd0);
    check({tag, "_bus_valid"}, 32'(bus_valid), 32'd0);
    check({tag, "_bus_ch"}, 32'(bus_ch), 32'd0);
    check({tag, "_bus_eve"}, 32'(bus_eve), 32'd0);
    check({tag, "_bus_pol"}, 32'(bus_pol_eve), 32'd0);
    check({tag, "_ack"}, 32'(ch_ack), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  logic [4:0] gray_exp [8] = '{5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4, 5'd12};
  logic [1:0] ch_exp   [8] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3};

  initial begin
    repeat (2) @(negedge clk_master);
    check_all_zero("reset");

    // Free-running schedule with no data.
    reset = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_master);
      check("gray_seq", 32'(gray), 32'(gray_exp[i]));
      check("slot_seq", 32'(bus_ch), 32'(ch_exp[i]));
    end
    wait_count(5'd16);
    check("idle16_ch_hold", 32'(bus_ch), 32'd0);
    check("idle16_valid", 32'(bus_valid), 32'd0);

    // Single sample on channel 2, drained at count 4.
    wait_count(5'd1);
    ch_valid = 4'b0100; ch_eve = 4'b0100; ch_pol_eve = 4'b0000;
    exp_q.push_back('{ch: 2'd2, eve: 1'b1, pol: 1'b0, cnt: 5'd4});
    @(negedge clk_master);
    ch_valid = '0;
    check("ack_ch2", 32'(ch_ack), 32'h4);
    @(negedge clk_master);
    check("ack_ch2_pulse", 32'(ch_ack), 32'h0);

    // Overflow on channel 3: A kept, B dropped.
    wait_count(5'd0);
    ch_valid = 4'b1000; ch_eve = 4'b1000; ch_pol_eve = 4'b1000;
    exp_q.push_back('{ch: 2'd3, eve: 1'b1, pol: 1'b1, cnt: 5'd8});
    @(negedge clk_master);
    ch_valid = '0;
    check("ack_ch3_a", 32'(ch_ack), 32'h8);
    wait_count(5'd3);
    ch_valid = 4'b1000; ch_eve = 4'b0000; ch_pol_eve = 4'b1000;
    @(negedge clk_master);
    ch_valid = '0;
    check("ack_ch3_b_dropped", 32'(ch_ack), 32'h0);
    check("ovf_ch3", 32'(ovf), 32'h8);

    // Drain and capture on channel 0 in the same cycle.
    wait_count(5'd3);
    ch_valid = 4'b0001; ch_eve = 4'b0001; ch_pol_eve = 4'b0000;
    exp_q.push_back('{ch: 2'd0, eve: 1'b1, pol: 1'b0, cnt: 5'd5});
    @(negedge clk_master);
    ch_valid = 4'b0001; ch_eve = 4'b0000; ch_pol_eve = 4'b0001;
    exp_q.push_back('{ch: 2'd0, eve: 1'b0, pol: 1'b1, cnt: 5'd7});
    check("ack_ch0_a", 32'(ch_ack), 32'h1);
    @(negedge clk_master);
    ch_valid = '0;
    check("ack_ch0_b", 32'(ch_ack), 32'h1);
    check("ovf_ch0_clear", 32'(ovf), 32'h8);
    wait_count(5'd8);

    // Disabled schedule: counter frozen, capture still works.
    en = 1'b0;
    ch_valid = 4'b0010; ch_eve = 4'b0010; ch_pol_eve = 4'b0000;
    @(negedge clk_master);
    ch_valid = '0;
    check("ack_ch1_disabled", 32'(ch_ack), 32'h2);
    repeat (9) @(negedge clk_master);
    check("gray_frozen", 32'(gray), 32'(5'd8 ^ 5'd4));

    // Reset with channel 1 pending; its data must never reach the bus.
    reset = 1'b1;
    en    = 1'b1;
    @(negedge clk_master);
    check_all_zero("midreset");
    reset = 1'b0;
    repeat (40) @(negedge clk_master);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
